// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - ID-stage hazard scoreboard, operand forwarding and interlock stall
// Build option: define HAZ_FWD_EN for forwarding; leave it undefined for an interlock-only unit.
module pipe_hazard_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NSTAGE = 3,
    parameter int LAT_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic                     id_reg1_read,
    input  logic [ADDR_W-1:0]        id_reg1_addr,
    input  logic                     id_reg2_read,
    input  logic [ADDR_W-1:0]        id_reg2_addr,
    input  logic [DATA_W-1:0]        id_reg1_rf,
    input  logic [DATA_W-1:0]        id_reg2_rf,
    input  logic                     id_wreg,
    input  logic [ADDR_W-1:0]        id_wd,
    input  logic [LAT_W-1:0]         id_lat,
    input  logic [NSTAGE*DATA_W-1:0] stg_wdata,
    output logic [DATA_W-1:0]        fwd_reg1_o,
    output logic [DATA_W-1:0]        fwd_reg2_o,
    output logic                     stall_o,
    output logic [31:0]              stall_cnt_o
);

    localparam int LAT_MAX = NSTAGE - 1;

    logic [NSTAGE-1:0] sb_v;
    logic [ADDR_W-1:0] sb_wd  [NSTAGE];
    logic [LAT_W-1:0]  sb_lat [NSTAGE];
    logic [LAT_W-1:0]  lat_in;
    logic [31:0]       stall_cnt_q;

    logic              hit1, rdy1, hit2, rdy2;
    logic [DATA_W-1:0] data1, data2;
    logic              need1, need2;
    logic [DATA_W-1:0] val1, val2;

    assign lat_in = (int'(id_lat) > LAT_MAX) ? LAT_W'(LAT_MAX) : id_lat;

    // Returns {hit, ready, data}; scanning oldest to youngest lets the youngest match win.
    function automatic logic [DATA_W+1:0] lookup(input logic rd, input logic [ADDR_W-1:0] addr);
        logic [DATA_W+1:0] r;
        r = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (rd && sb_v[i] && (sb_wd[i] == addr) && (addr != '0)) begin
                r = {1'b1, (i >= int'(sb_lat[i])), stg_wdata[i*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    always_comb begin
        {hit1, rdy1, data1} = lookup(id_reg1_read, id_reg1_addr);
        {hit2, rdy2, data2} = lookup(id_reg2_read, id_reg2_addr);
    end

`ifdef HAZ_FWD_EN
    always_comb begin
        need1 = hit1 & ~rdy1;
        need2 = hit2 & ~rdy2;
        val1  = (hit1 & rdy1) ? data1 : id_reg1_rf;
        val2  = (hit2 & rdy2) ? data2 : id_reg2_rf;
    end
`else
    logic fwd_unused;
    assign fwd_unused = ^{rdy1, rdy2, data1, data2};

    // Without forwarding any in-flight producer blocks the read until it has retired.
    always_comb begin
        need1 = hit1;
        need2 = hit2;
        val1  = id_reg1_rf;
        val2  = id_reg2_rf;
    end
`endif

    assign stall_o     = ~rst & id_valid & (need1 | need2);
    assign fwd_reg1_o  = rst ? '0 : val1;
    assign fwd_reg2_o  = rst ? '0 : val2;
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_v        <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                sb_wd[i]  <= '0;
                sb_lat[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NSTAGE; i++) begin
                sb_v[i]   <= sb_v[i-1];
                sb_wd[i]  <= sb_wd[i-1];
                sb_lat[i] <= sb_lat[i-1];
            end
            // A stalled ID instruction enters the scoreboard as a bubble.
            sb_v[0]   <= id_valid & id_wreg & (id_wd != '0) & ~stall_o;
            sb_wd[0]  <= id_wd;
            sb_lat[0] <= lat_in;
            if (stall_o) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

endmodule
